seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Multi-cycle unsigned integer divider built from the same subtract/compare datapath as the team's adder family. It accepts an N-bit dividend and divisor on a start pulse and computes quotient and remainder with one restoring-division step per clock. It signals completion with a one-cycle done pulse. It sits beside the combinational adders as the arithmetic unit for operations too wide or slow to resolve in one cycle.

## Interface
- N, 4, operand/result width in bits (N ≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  N  unsigned dividend, sampled with start
- divisor  input  N  unsigned divisor, sampled with start
- busy  output  1  high while iterating (CALC state)
- done  output  1  one-cycle completion pulse
- quotient  output  [N-1:0]  registered quotient, held until next completion
- remainder  output  [N-1:0]  registered remainder, held until next completion
- div_by_zero  output  1  registered flag, valid with and held like quotient

## Operation
- States: IDLE, CALC, DONE. Reset (rst_n low, asynchronous) forces IDLE and clears busy, done, quotient, remainder, div_by_zero, and the iteration counter to 0.
- IDLE to CALC: start=1 and divisor≠0. Load Q←dividend and D←divisor. Clear the partial remainder R (N+1 bits) and set count←0.
- IDLE to DONE: start=1 and divisor=0. On the same edge, register quotient←all ones, remainder←dividend, div_by_zero←1. No CALC cycles run.
- CALC step, one per edge:
  - {R,Q} ← {R,Q} shifted left by 1.
  - T ← R_shifted − {1'b0,D}, computed in N+1 bits.
  - If T's MSB is 0: R←T and Q[0]←1. Otherwise R is kept (restore) and Q[0]←0.
  - count←count+1.
- CALC to DONE: on the edge that performs step N (count = N−1 before the edge). That edge also registers quotient←final Q, remainder←final R[N-1:0], div_by_zero←0.
- DONE to IDLE: unconditionally on the next edge.
- start is ignored in CALC and DONE. A start in DONE is dropped, not queued.
- Operands are captured at acceptance, so later changes on dividend/divisor do not affect the operation in flight.
- Result invariant for divisor≠0: dividend = quotient·divisor + remainder, with remainder < divisor.
- Width rules:
  - R is N+1 bits so the trial subtraction never overflows.
  - count is ceil(log2(N)) bits minimum and must not wrap before reaching N−1.

## Timing
- Acceptance edge is E0 (start=1 sampled in IDLE).
- divisor≠0:
  - busy is high from after E0 until after edge E_N, i.e. N cycles.
  - Results update on E_N. done is high for exactly one cycle, from E_N to E_N+1.
  - Latency from start edge to results: N cycles.
  - Earliest next acceptance is E_N+2, so throughput is one operation per N+2 cycles.
- divisor=0:
  - Results update on E0 and done is high from E0 to E1. busy stays 0.
  - Earliest next acceptance is E2.
- quotient, remainder and div_by_zero change only on completion edges or reset. They are stable whenever done=1.
- Reset mid-operation (rst_n low in CALC or DONE):
  - Immediately IDLE, with all outputs 0 and no done pulse.
  - The first start after rst_n rises is accepted normally.
- Reset deassertion is assumed synchronous to clk by the surrounding reset synchronizer.

## Test plan
- N=4, dividend=13, divisor=3, start pulsed once -> busy high 4 cycles; done exactly 4 cycles after acceptance edge; quotient=4, remainder=1, div_by_zero=0.
- Boundary values (N=4):
  - 15/1 -> quotient=15, remainder=0.
  - 5/7 -> quotient=0, remainder=5.
  - 15/15 -> quotient=1, remainder=0.
  - 0/9 -> quotient=0, remainder=0.
- 9/0 -> busy never asserts; done 1 cycle after acceptance; quotient=4'b1111, remainder=9, div_by_zero=1. Next start 6/2 -> quotient=3, remainder=0, div_by_zero=0.
- Start held high continuously with 11/2 -> one result per 6 cycles (quotient=5, remainder=1). Operand changes during CALC do not alter the result. Start in the DONE cycle is dropped.
- rst_n pulsed low two cycles into a 14/3 operation -> outputs 0 immediately, no done pulse. Following 14/3 -> quotient=4, remainder=2 with normal latency.
- Exhaustive sweep of all 256 (dividend, divisor) pairs for N=4 plus random pairs for N=8 -> every result matches a reference model; divisor=0 cases follow the divide-by-zero rule.

Source files
------------

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/operand request and result bundle for the sequential divider
//   master drives start, dividend, divisor and watches busy/done/results
//   slave (the divider) drives busy, done, quotient, remainder, div_by_zero
interface seq_restoring_divider_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: N-bit unsigned restoring divider, one quotient bit per clock
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   io (slave) : start/dividend/divisor in; busy, done pulse, quotient, remainder, div_by_zero out
module seq_restoring_divider #(
    parameter int N = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    seq_restoring_divider_if.slave io
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic [N:0]    rs, t;
    // r_q only holds N bits: a kept remainder is always below the divisor
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rs          = {r_q, q_q[N-1]};
        t           = rs - {1'b0, d_q};
        unique case (state_q)
            IDLE: if (io.start) begin
                if (io.divisor == '0) begin
                    state_d     = DONE;
                    quotient_d  = '1;
                    remainder_d = io.dividend;
                    dbz_d       = 1'b1;
                end else begin
                    state_d = CALC;
                    q_d     = io.dividend;
                    d_d     = io.divisor;
                    r_d     = '0;
                    count_d = '0;
                end
            end
            CALC: begin
                r_d     = t[N] ? rs[N-1:0] : t[N-1:0];
                q_d     = {q_q[N-2:0], ~t[N]};
                count_d = count_q + 1'b1;
                if (count_q == CW'(N - 1)) begin
                    state_d     = DONE;
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    dbz_d       = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end
    assign io.busy        = state_q == CALC;
    assign io.done        = state_q == DONE;
    assign io.quotient    = quotient_q;
    assign io.remainder   = remainder_q;
    assign io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and sweep checks of the restoring divider at N=4 and N=8
module tb_seq_restoring_divider;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    seq_restoring_divider_if #(.N(4)) f4 ();
    seq_restoring_divider_if #(.N(8)) f8 ();
    seq_restoring_divider #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .io(f4));
    seq_restoring_divider #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .io(f8));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    // called at a negedge with the divider idle; returns at a negedge with it idle again
    task automatic op4(input int a, input int b);
        int lat;
        int busy_n;
        f4.start    = 1'b1;
        f4.dividend = 4'(a);
        f4.divisor  = 4'(b);
        @(negedge clk);
        f4.start    = 1'b0;
        f4.dividend = 4'($urandom);
        f4.divisor  = 4'($urandom);
        lat = 0;
        busy_n = 0;
        while (!f4.done && lat < 20) begin
            busy_n += int'(f4.busy);
            @(negedge clk);
            lat++;
        end
        busy_n += int'(f4.busy);
        check("done4", 32'(f4.done), 1);
        check("lat4", lat, b == 0 ? 0 : 4);
        check("busy4", busy_n, b == 0 ? 0 : 4);
        check("quo4", 32'(f4.quotient), b == 0 ? 15 : a / b);
        check("rem4", 32'(f4.remainder), b == 0 ? a : a % b);
        check("dbz4", 32'(f4.div_by_zero), b == 0 ? 1 : 0);
        @(negedge clk);
        check("pulse4", 32'(f4.done), 0);
    endtask
    task automatic op8(input int a, input int b);
        int lat;
        f8.start    = 1'b1;
        f8.dividend = 8'(a);
        f8.divisor  = 8'(b);
        @(negedge clk);
        f8.start    = 1'b0;
        f8.dividend = 8'($urandom);
        f8.divisor  = 8'($urandom);
        lat = 0;
        while (!f8.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("lat8", lat, b == 0 ? 0 : 8);
        check("quo8", 32'(f8.quotient), b == 0 ? 255 : a / b);
        check("rem8", 32'(f8.remainder), b == 0 ? a : a % b);
        check("dbz8", 32'(f8.div_by_zero), b == 0 ? 1 : 0);
        @(negedge clk);
    endtask
    initial begin
        rst_n = 1'b0;
        f4.start = 1'b0; f4.dividend = '0; f4.divisor = '0;
        f8.start = 1'b0; f8.dividend = '0; f8.divisor = '0;
        @(negedge clk);
        check("rst_busy", 32'(f4.busy), 0);
        check("rst_done", 32'(f4.done), 0);
        check("rst_quo", 32'(f4.quotient), 0);
        check("rst_rem", 32'(f4.remainder), 0);
        check("rst_dbz", 32'(f4.div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);
        op4(13, 3);
        op4(15, 1);
        op4(5, 7);
        op4(15, 15);
        op4(0, 9);
        op4(9, 0);
        op4(6, 2);
        // start held high: accepted at E0, E6, E12; operand changes mid-CALC and start in DONE ignored
        f4.start    = 1'b1;
        f4.dividend = 4'd11;
        f4.divisor  = 4'd2;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 2) begin f4.dividend = 4'd7; f4.divisor = 4'd3; end
            if (k == 4) begin f4.dividend = 4'd11; f4.divisor = 4'd2; end
            check("hold_done", 32'(f4.done), (k == 5 || k == 11 || k == 17) ? 1 : 0);
            if (k == 5 || k == 11 || k == 17) begin
                check("hold_quo", 32'(f4.quotient), 5);
                check("hold_rem", 32'(f4.remainder), 1);
            end
        end
        f4.start = 1'b0;
        @(negedge clk);
        // asynchronous reset two cycles into 14/3
        f4.start    = 1'b1;
        f4.dividend = 4'd14;
        f4.divisor  = 4'd3;
        @(negedge clk);
        f4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(f4.busy), 1);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(f4.busy), 0);
        check("mrst_done", 32'(f4.done), 0);
        check("mrst_quo", 32'(f4.quotient), 0);
        check("mrst_rem", 32'(f4.remainder), 0);
        check("mrst_dbz", 32'(f4.div_by_zero), 0);
        @(negedge clk);
        check("mrst_done2", 32'(f4.done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_done", 32'(f4.done), 0);
        check("post_busy", 32'(f4.busy), 0);
        op4(14, 3);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(a, b);
        for (int i = 0; i < 40; i++)
            op8(int'($urandom_range(0, 255)), (i % 8 == 0) ? 0 : int'($urandom_range(1, 255)));
        op8(255, 1);
        op8(200, 255);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
